i2cm_seq: RTL
=============

Name: i2cm_seq

Overview:
- Transaction sequencer that drives the i2cm command interface (cmds/cdone, tbyte/rbyte, rxack, error) in place of software register pokes.
- Accepts one-byte register read/write requests: device address, register index, data.
- Expands each request into the START/WRITE/READ/STOP command sequence and returns a single response.
- Sits between a host-side request port and the i2cm bit engine.

Parameters:
- TIMEOUT, 16'd50000, max cycles to wait for a command's cdone before abort; 0 disables the timeout.
- MAX_RETRY, 2, address-NACK retries (only with I2CM_SEQ_RETRY_EN).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- ena  in  1  sequencer enable; low forces IDLE synchronously
- req_valid  in  1  request valid
- req_ready  out  1  request accepted when valid&&ready
- req_rnw  in  1  1=read, 0=write
- req_dev  in  7  7-bit device address
- req_reg  in  8  register index
- req_wdata  in  8  write data
- rsp_valid  out  1  response valid, held until rsp_ready
- rsp_ready  in  1  response consumed
- rsp_rdata  out  8  read data (0 for writes)
- rsp_nack  out  1  slave NACKed a byte
- rsp_err  out  1  engine error or timeout
- cmds  out  5  one-hot command to engine: bit0 START, bit1 WRITE, bit2 READ, bit3 TXACK, bit4 STOP
- cdone  in  5  per-command done pulses from engine
- tbyte  out  8  byte for WRITE command
- rbyte  in  8  byte from READ command
- rxack  in  1  ACK bit sampled after WRITE (0=ACK)
- error  in  1  engine bus/arbitration error

Behaviour:
- Clock and reset: single clock clk; reset is asynchronous and active-low on rst_n.
- Reset values: all outputs 0, including cmds=0, tbyte=0, req_ready=0 and rsp_valid=0. FSM resets to IDLE. req_ready rises in the first cycle after reset release if ena=1.
- req_ready: equals (state==IDLE && ena && !rsp_valid).
  - On accept, latch rnw/dev/reg/wdata.
  - Next cycle: cmds=START.
- Command issue rule:
  - cmds and tbyte are registered.
  - Exactly one cmds bit is set at a time.
  - That bit is held until the matching cdone bit is sampled high; it clears on that same clock edge.
  - The next command asserts one cycle later (one idle cycle between commands).
  - cdone bits not matching the active command are ignored.
- Write sequence: START -> WRITE(tbyte={dev,0}) -> WRITE(reg) -> WRITE(wdata) -> STOP -> RESP.
- Read sequence: START -> WRITE({dev,0}) -> WRITE(reg) -> START (repeated) -> WRITE({dev,1}) -> READ -> STOP -> RESP.
  - READ is issued without TXACK, so the engine returns master NACK for the single byte.
  - rbyte is captured into rsp_rdata on READ's cdone.
- rxack check: sampled on each WRITE's cdone. If rxack=1, skip remaining bytes, issue STOP, then RESP with rsp_nack=1.
- error: if error=1 in any non-IDLE/non-RESP state:
  - Clear cmds immediately.
  - Go to RESP with rsp_err=1; no STOP is issued.
  - error has priority over cdone in the same cycle.
- Timeout: a 16-bit counter clears on each command assertion and counts while waiting for cdone. If TIMEOUT!=0 and count reaches TIMEOUT: cmds=0, rsp_err=1, go to RESP.
- RESP state:
  - rsp_valid=1; rsp_rdata, rsp_nack and rsp_err are stable.
  - On rsp_valid&&rsp_ready: clear rsp_* and go to IDLE.
  - Total latency from accept to rsp_valid = sum of engine command times + one cycle per command + 1.
- ena low: cmds=0, FSM to IDLE, rsp_valid cleared, latched request discarded. The engine is expected to be cleared externally at the same time.
- rsp flags never set simultaneously except rsp_nack=0 / rsp_err=1 combinations; rsp_rdata=0 on any error or NACK.

Optional Feature:
- Macro I2CM_SEQ_RETRY_EN.
- Defined:
  - A NACK on the first device-address WRITE (either phase) issues STOP, then restarts the whole sequence from START.
  - Up to MAX_RETRY times; a 2-bit retry counter is reset on accept.
  - rsp_nack is set only after retries are exhausted.
  - NACK on reg/data bytes is not retried.
- Undefined: no retry; any NACK goes to STOP then RESP with rsp_nack=1. MAX_RETRY is unused.

Test Plan:
- Write dev=0x50 reg=0x10 data=0xA5, engine model ACKs all -> cmds sequence 01,02(tbyte=A0),02(tbyte=10),02(tbyte=A5),10; rsp_valid with nack=0, err=0, rdata=00.
- Read dev=0x50 reg=0x20, model returns rbyte=0x3C -> cmds 01,02(A0),02(20),01,02(A1),04,10; rsp_rdata=3C, nack=0.
- Write with rxack=1 on reg byte -> next cmd is STOP (10), no data WRITE; rsp_nack=1.
  - With I2CM_SEQ_RETRY_EN and MAX_RETRY=2, address NACK on every try -> 3 START commands, then rsp_nack=1.
- error=1 pulsed during second WRITE -> cmds=0 next edge, no STOP; rsp_err=1. A new request is accepted after rsp_ready.
- TIMEOUT=100, model never returns cdone for START -> cmds=0 after 100 wait cycles; rsp_err=1.
- Mid-transaction: ena=0 -> cmds=0, rsp_valid=0 next cycle. Async rst_n low during READ -> all outputs 0 immediately, req_ready=1 after release with ena=1.

Source files
------------

// File: rtl/i2cm_seq.sv
// -----------------------------------------------------------------------------
// i2cm_seq
//   Transaction sequencer for the i2cm bit engine. A host issues one-byte
//   register read/write requests; the sequencer expands each one into the
//   START / WRITE / READ / STOP command sequence on the engine's command port
//   and returns a single response.
//
//   Optional feature (macro I2CM_SEQ_RETRY_EN): a NACK on a device-address
//   WRITE issues STOP and restarts the whole sequence, up to MAX_RETRY times.
//   When the macro is not defined, any NACK ends the transaction.
//
// Handshakes (both ports): a transfer happens on a rising clk edge where
// valid && ready are both high. req_* must be stable while req_valid is high.
// rsp_valid stays high, with stable rsp_* fields, until rsp_ready is seen.
//
// Ports
//   clk, rst_n   clock, asynchronous active-low reset
//   ena          enable; low returns the sequencer to IDLE synchronously
//   req_*        request port (rnw, 7-bit dev, reg index, write data)
//   rsp_*        response port (read data, nack flag, error flag)
//   cmds         one-hot engine command: [0]START [1]WRITE [2]READ [3]TXACK [4]STOP
//   cdone        per-command done pulses from the engine
//   tbyte        byte for a WRITE command
//   rbyte        byte returned by a READ command
//   rxack        ACK bit after a WRITE (0 = ACK)
//   error        engine bus/arbitration error
//   state_dbg    current FSM state (debug observation only)
// -----------------------------------------------------------------------------
module i2cm_seq #(
  parameter logic [15:0] TIMEOUT   = 16'd50000,
  parameter int          MAX_RETRY = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_rnw,
  input  logic [6:0] req_dev,
  input  logic [7:0] req_reg,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_rdata,
  output logic       rsp_nack,
  output logic       rsp_err,
  output logic [4:0] cmds,
  input  logic [4:0] cdone,
  output logic [7:0] tbyte,
  input  logic [7:0] rbyte,
  input  logic       rxack,
  input  logic       error,
  output logic [3:0] state_dbg
);

  // Each non-IDLE/non-RESP state names the command it issues. issued_q
  // distinguishes the idle gap cycle (0) from waiting on cdone (1).
  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_START  = 4'd1,
    ST_WDEV   = 4'd2,
    ST_WREG   = 4'd3,
    ST_WDATA  = 4'd4,
    ST_RSTART = 4'd5,
    ST_WDEVR  = 4'd6,
    ST_READ   = 4'd7,
    ST_STOP   = 4'd8,
    ST_RESP   = 4'd9
  } state_t;

  localparam logic [4:0] CMD_START = 5'b00001;
  localparam logic [4:0] CMD_WRITE = 5'b00010;
  localparam logic [4:0] CMD_READ  = 5'b00100;
  localparam logic [4:0] CMD_STOP  = 5'b10000;

  state_t      state_q, state_d;
  logic        issued_q, issued_d;
  logic [4:0]  cmds_q, cmds_d;
  logic [7:0]  tbyte_q, tbyte_d;
  logic [15:0] timer_q, timer_d;
  logic        rnw_q, rnw_d;
  logic [6:0]  dev_q, dev_d;
  logic [7:0]  regidx_q, regidx_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [7:0]  rsp_rdata_q, rsp_rdata_d;
  logic        rsp_nack_q, rsp_nack_d;
  logic        rsp_err_q, rsp_err_d;
  logic        nack_pend_q, nack_pend_d;   // NACK seen, reported after STOP
  logic        retry_pend_q, retry_pend_d; // restart from START after STOP
  logic        run_q;                      // low for the first cycle after reset

  logic        cmd_hit;
  logic        timeout_hit;
  logic        is_write;
  logic        retry_ok;

`ifdef I2CM_SEQ_RETRY_EN
  logic [1:0]  retry_q, retry_d;
`endif

  assign req_ready = run_q && (state_q == ST_IDLE) && ena && !rsp_valid_q;

  assign cmd_hit  = |(cdone & cmds_q);
  assign is_write = (state_q == ST_WDEV) || (state_q == ST_WREG) ||
                    (state_q == ST_WDATA) || (state_q == ST_WDEVR);

  // The counter sits at TIMEOUT-1 on the edge where the TIMEOUT-th wait
  // cycle ends, so the command stays asserted exactly TIMEOUT cycles.
  assign timeout_hit = (TIMEOUT != 16'd0) && issued_q &&
                       (timer_q == (TIMEOUT - 16'd1));

`ifdef I2CM_SEQ_RETRY_EN
  assign retry_ok = ((state_q == ST_WDEV) || (state_q == ST_WDEVR)) &&
                    (retry_q < 2'(MAX_RETRY));
`else
  logic unused_max_retry;
  assign unused_max_retry = (MAX_RETRY != 0);
  assign retry_ok = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    issued_d     = issued_q;
    cmds_d       = cmds_q;
    tbyte_d      = tbyte_q;
    timer_d      = timer_q;
    rnw_d        = rnw_q;
    dev_d        = dev_q;
    regidx_d     = regidx_q;
    wdata_d      = wdata_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_rdata_d  = rsp_rdata_q;
    rsp_nack_d   = rsp_nack_q;
    rsp_err_d    = rsp_err_q;
    nack_pend_d  = nack_pend_q;
    retry_pend_d = retry_pend_q;
`ifdef I2CM_SEQ_RETRY_EN
    retry_d      = retry_q;
`endif

    if (!ena) begin
      // Abandon everything; the engine is cleared externally alongside.
      state_d      = ST_IDLE;
      issued_d     = 1'b0;
      cmds_d       = '0;
      tbyte_d      = '0;
      timer_d      = '0;
      rsp_valid_d  = 1'b0;
      rsp_rdata_d  = '0;
      rsp_nack_d   = 1'b0;
      rsp_err_d    = 1'b0;
      nack_pend_d  = 1'b0;
      retry_pend_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid && req_ready) begin
            rnw_d        = req_rnw;
            dev_d        = req_dev;
            regidx_d     = req_reg;
            wdata_d      = req_wdata;
            state_d      = ST_START;
            cmds_d       = CMD_START;
            tbyte_d      = '0;
            issued_d     = 1'b1;
            timer_d      = '0;
            rsp_rdata_d  = '0;
            rsp_nack_d   = 1'b0;
            rsp_err_d    = 1'b0;
            nack_pend_d  = 1'b0;
            retry_pend_d = 1'b0;
`ifdef I2CM_SEQ_RETRY_EN
            retry_d      = '0;
`endif
          end
        end

        ST_RESP: begin
          if (rsp_ready) begin
            state_d     = ST_IDLE;
            rsp_valid_d = 1'b0;
            rsp_rdata_d = '0;
            rsp_nack_d  = 1'b0;
            rsp_err_d   = 1'b0;
          end
        end

        default: begin
          if (error) begin
            // Error wins over a same-cycle cdone; no STOP is attempted.
            state_d     = ST_RESP;
            issued_d    = 1'b0;
            cmds_d      = '0;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_nack_d  = 1'b0;
            rsp_rdata_d = '0;
          end else if (!issued_q) begin
            // Gap cycle over: assert the command this state stands for.
            issued_d = 1'b1;
            timer_d  = '0;
            tbyte_d  = '0;
            case (state_q)
              ST_START, ST_RSTART: cmds_d = CMD_START;
              ST_WDEV: begin
                cmds_d  = CMD_WRITE;
                tbyte_d = {dev_q, 1'b0};
              end
              ST_WREG: begin
                cmds_d  = CMD_WRITE;
                tbyte_d = regidx_q;
              end
              ST_WDATA: begin
                cmds_d  = CMD_WRITE;
                tbyte_d = wdata_q;
              end
              ST_WDEVR: begin
                cmds_d  = CMD_WRITE;
                tbyte_d = {dev_q, 1'b1};
              end
              ST_READ:  cmds_d = CMD_READ;   // no TXACK: master NACKs the byte
              ST_STOP:  cmds_d = CMD_STOP;
              default:  cmds_d = '0;
            endcase
          end else if (cmd_hit) begin
            cmds_d   = '0;
            issued_d = 1'b0;
            if (is_write && rxack) begin
              state_d = ST_STOP;
              if (retry_ok) retry_pend_d = 1'b1;
              else          nack_pend_d  = 1'b1;
            end else begin
              case (state_q)
                ST_START:  state_d = ST_WDEV;
                ST_WDEV:   state_d = ST_WREG;
                ST_WREG:   state_d = rnw_q ? ST_RSTART : ST_WDATA;
                ST_WDATA:  state_d = ST_STOP;
                ST_RSTART: state_d = ST_WDEVR;
                ST_WDEVR:  state_d = ST_READ;
                ST_READ: begin
                  rsp_rdata_d = rbyte;
                  state_d     = ST_STOP;
                end
                ST_STOP: begin
                  if (retry_pend_q) begin
                    retry_pend_d = 1'b0;
                    state_d      = ST_START;
`ifdef I2CM_SEQ_RETRY_EN
                    retry_d      = retry_q + 2'd1;
`endif
                  end else begin
                    state_d     = ST_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_nack_d  = nack_pend_q;
                  end
                end
                default:   state_d = ST_IDLE;
              endcase
            end
          end else if (timeout_hit) begin
            state_d     = ST_RESP;
            issued_d    = 1'b0;
            cmds_d      = '0;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_nack_d  = 1'b0;
            rsp_rdata_d = '0;
          end else begin
            timer_d = timer_q + 16'd1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      issued_q     <= 1'b0;
      cmds_q       <= '0;
      tbyte_q      <= '0;
      timer_q      <= '0;
      rnw_q        <= 1'b0;
      dev_q        <= '0;
      regidx_q     <= '0;
      wdata_q      <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= '0;
      rsp_nack_q   <= 1'b0;
      rsp_err_q    <= 1'b0;
      nack_pend_q  <= 1'b0;
      retry_pend_q <= 1'b0;
      run_q        <= 1'b0;
`ifdef I2CM_SEQ_RETRY_EN
      retry_q      <= '0;
`endif
    end else begin
      state_q      <= state_d;
      issued_q     <= issued_d;
      cmds_q       <= cmds_d;
      tbyte_q      <= tbyte_d;
      timer_q      <= timer_d;
      rnw_q        <= rnw_d;
      dev_q        <= dev_d;
      regidx_q     <= regidx_d;
      wdata_q      <= wdata_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_nack_q   <= rsp_nack_d;
      rsp_err_q    <= rsp_err_d;
      nack_pend_q  <= nack_pend_d;
      retry_pend_q <= retry_pend_d;
      run_q        <= 1'b1;
`ifdef I2CM_SEQ_RETRY_EN
      retry_q      <= retry_d;
`endif
    end
  end

  assign cmds      = cmds_q;
  assign tbyte     = tbyte_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_nack  = rsp_nack_q;
  assign rsp_err   = rsp_err_q;
  assign state_dbg = state_q;

endmodule
